// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
// Shared definitions for the stream_mux block:
//   - state_e   : packet FSM states (ST_IDLE waits for a request, ST_LOCK holds
//                 the grant until the packet's last beat has been accepted)
//   - sel_width : width of a channel index, kept at least 1 bit so a
//                 single-channel build still has a legal index vector
// -----------------------------------------------------------------------------
package stream_mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // clog2 that never returns 0, so N = 1 still yields a 1-bit index
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_arb.sv
// -----------------------------------------------------------------------------
// stream_mux_arb
// Combinational N-way picker used by stream_mux while it is idle.
// Build option: STREAM_MUX_RR_EN
//   undefined : fixed priority, lowest requesting index wins
//   defined   : round robin, first requester at or after rr_ptr_i (wrapping)
// Ports:
//   req_i     [N-1:0]     request vector (one bit per channel)
//   rr_ptr_i  [SEL_W-1:0] search start index (only with STREAM_MUX_RR_EN)
//   idx_o     [SEL_W-1:0] picked channel, 0 when nothing requests
//   any_o                 at least one request present
// -----------------------------------------------------------------------------
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req_i,
`ifdef STREAM_MUX_RR_EN
    input  logic [SEL_W-1:0] rr_ptr_i,
`endif
    output logic [SEL_W-1:0] idx_o,
    output logic             any_o
);

    // Walk the channels in search order and keep the first requester found.
    always_comb begin
        int             ch;
        logic           found;
        logic [N-1:0]   hit;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
`ifdef STREAM_MUX_RR_EN
            ch = (int'(rr_ptr_i) + k) % N;
`else
            ch = k;
`endif
            // shift instead of a variable bit-select keeps the index width clean
            hit = req_i >> ch;
            if (!found && hit[0]) begin
                idx_o = SEL_W'(ch);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/stream_mux.sv
// -----------------------------------------------------------------------------
// stream_mux
// N-channel valid/ready stream multiplexer with packet locking and a single
// registered output stage. A channel is picked while idle, keeps the grant for
// its whole packet (until a beat with in_last is accepted), and every accepted
// beat lands in the output register tagged with its source channel.
// Build option: STREAM_MUX_RR_EN selects round-robin arbitration (adds the
// rr_ptr register); without it the lowest-index requester always wins.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid  [N-1:0]     per-channel beat valid
//   in_data   [N*WIDTH-1:0] channel i at [i*WIDTH +: WIDTH]
//   in_last   [N-1:0]     per-channel end-of-packet
//   in_ready  [N-1:0]     per-channel accept, one-hot or zero
//   out_valid/out_data/out_last/out_src  registered output beat
//   out_ready             consumer accept
// -----------------------------------------------------------------------------
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_src,
    input  logic               out_ready
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;

    logic [WIDTH-1:0] chan_data_s [N];
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_valid_s;
    logic             sel_last_s;
    logic             can_load_s;
    logic             xfer_s;
    logic             pkt_end_s;
    logic [SEL_W-1:0] arb_idx_s;
    logic             arb_any_s;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    stream_mux_arb #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req_i    (in_valid),
`ifdef STREAM_MUX_RR_EN
        .rr_ptr_i (rr_ptr_q),
`endif
        .idx_o    (arb_idx_s),
        .any_o    (arb_any_s)
    );

    // Route the granted channel and decide whether a beat moves this cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            chan_data_s[i] = in_data[i*WIDTH +: WIDTH];
        end
        sel_valid_s = in_valid[grant_q];
        sel_last_s  = in_last[grant_q];
        sel_data_s  = chan_data_s[grant_q];
        // the output register can take a beat when empty or draining now
        can_load_s  = !out_valid_q || out_ready;
        xfer_s      = (state_q == ST_LOCK) && sel_valid_s && can_load_s;
        pkt_end_s   = xfer_s && sel_last_s;
    end

    // Only the granted channel sees ready, and only while locked.
    always_comb begin
        in_ready = '0;
        if (state_q == ST_LOCK) begin
            in_ready[grant_q] = can_load_s;
        end else begin
            in_ready = '0;
        end
    end

    // Packet FSM: arbitrate in IDLE, hold the grant in LOCK until the last beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    state_d = ST_LOCK;
                    grant_d = arb_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (pkt_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output register: load on input transfer, clear on drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_last_d  = sel_last_s;
            out_src_d   = grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, grant and output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

`ifdef STREAM_MUX_RR_EN
    // Advance the search start past the channel whose packet just ended.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pkt_end_s) begin
            if (grant_q == SEL_W'(N - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_q + SEL_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_stream_mux
// Self-checking bench for stream_mux (WIDTH=32, N=4). Producers are per-channel
// beat queues; a behavioural model (current owner channel, one-entry output
// slot, round-robin start) predicts in_ready and the output beat every cycle.
// Directed sections pin the model with hand-computed literals; a random
// section then exercises masks, packet lengths and back-pressure.
// -----------------------------------------------------------------------------
module tb_stream_mux;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [N-1:0]  rdy;
        logic          ov;
        logic [W-1:0]  d;
        logic          l;
        logic [SW-1:0] s;
    } snap_t;

    typedef struct packed {
        logic [SW-1:0] s;
        logic          l;
        logic [W-1:0]  d;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_src;
    logic           out_ready;

    int checks   = 0;
    int failures = 0;

    // producer queues: {last, data}
    logic [W:0]   srcq [N][$];
    logic [N-1:0] en_mask;
    snap_t        hist[$];
    beat_t        otx[$];

    // behavioural model
    int           m_owner;
    bit           m_ov;
    logic [W-1:0] m_data;
    bit           m_last;
    int           m_src;
    int           m_ptr;

    stream_mux #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef STREAM_MUX_RR_EN
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ov = 1'b0; m_data = '0; m_last = 1'b0; m_src = 0; m_ptr = 0;
    endtask

    function automatic beat_t get_otx(input int k);
        if (k < otx.size()) return otx[k];
        return '0;
    endfunction

    function automatic bit busy();
        bit b;
        b = (m_owner >= 0) || m_ov;
        for (int c = 0; c < N; c++) if (srcq[c].size() != 0) b = 1'b1;
        return b;
    endfunction

    // One clock: drive producers, compare at negedge, advance model at posedge.
    task automatic cycle();
        logic [N-1:0] exp_rdy, vld_seen, rdy_seen;
        bit           acc, n_ov, n_last;
        logic [W-1:0] n_data;
        int           n_src, n_owner, n_ptr;
        snap_t        sn;
        for (int c = 0; c < N; c++) begin
            if (srcq[c].size() > 0 && en_mask[c]) begin
                in_valid[c]      = 1'b1;
                in_data[c*W +: W] = srcq[c][0][W-1:0];
                in_last[c]       = srcq[c][0][W];
            end else begin
                in_valid[c]      = 1'b0;
                in_data[c*W +: W] = $urandom;
                in_last[c]       = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        exp_rdy = '0;
        if (m_owner >= 0 && (!m_ov || out_ready)) exp_rdy[m_owner] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("out_data", 64'(out_data), 64'(m_data));
            chk("out_last", 64'(out_last), 64'(m_last));
            chk("out_src", 64'(out_src), 64'(m_src));
        end
        sn.rdy = in_ready; sn.ov = out_valid; sn.d = out_data; sn.l = out_last; sn.s = out_src;
        hist.push_back(sn);
        if (out_valid && out_ready) otx.push_back({out_src, out_last, out_data});
        vld_seen = in_valid;
        rdy_seen = in_ready;
        acc = (m_owner >= 0) && in_valid[m_owner] && exp_rdy[m_owner];
        n_ov = m_ov; n_data = m_data; n_last = m_last; n_src = m_src;
        if (acc) begin
            n_ov = 1'b1; n_data = in_data[m_owner*W +: W]; n_last = in_last[m_owner]; n_src = m_owner;
        end else if (out_ready) begin
            n_ov = 1'b0;
        end
        n_owner = m_owner; n_ptr = m_ptr;
        if (m_owner < 0) begin
            n_owner = pick(in_valid, m_ptr);
        end else if (acc && in_last[m_owner]) begin
            n_owner = -1;
            n_ptr   = (m_owner + 1) % N;
        end
        @(posedge clk);
        m_ov = n_ov; m_data = n_data; m_last = n_last; m_src = n_src;
        m_owner = n_owner; m_ptr = n_ptr;
        for (int c = 0; c < N; c++) if (vld_seen[c] && rdy_seen[c]) void'(srcq[c].pop_front());
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int c0, pushed, guard, len;
        beat_t b;
        rst_n = 1'b0; in_valid = '1; in_data = '0; in_last = '0;
        out_ready = 1'b1; en_mask = '1;
        model_reset();

        // ---- reset with all channels requesting ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) srcq[c].push_back({1'b1, 32'h1000_0000 + 32'(c)});
        otx.delete(); c0 = hist.size();
        run(12);
        chk("rel_idle_rdy", 64'(hist[c0].rdy), 64'h0);
        chk("rel_grant0_rdy", 64'(hist[c0+1].rdy), 64'h1);
        b = get_otx(0);
        chk("rel_first_src", 64'(b.s), 64'd0);

        // ---- single packet on channel 2 ----
        srcq[2].push_back({1'b0, 32'hA5A5_A5A5});
        srcq[2].push_back({1'b1, 32'h5A5A_5A5A});
        c0 = hist.size();
        run(6);
        chk("sp_rdy_k1", 64'(hist[c0+1].rdy), 64'h4);
        chk("sp_ov_k1", 64'(hist[c0+1].ov), 64'd0);
        chk("sp_ov_k2", 64'(hist[c0+2].ov), 64'd1);
        chk("sp_data_k2", 64'(hist[c0+2].d), 64'hA5A5_A5A5);
        chk("sp_last_k2", 64'(hist[c0+2].l), 64'd0);
        chk("sp_src_k2", 64'(hist[c0+2].s), 64'd2);
        chk("sp_data_k3", 64'(hist[c0+3].d), 64'h5A5A_5A5A);
        chk("sp_last_k3", 64'(hist[c0+3].l), 64'd1);
        chk("sp_src_k3", 64'(hist[c0+3].s), 64'd2);
        chk("sp_ov_k4", 64'(hist[c0+4].ov), 64'd0);

        // ---- packet lock: channel 1 stalls while channel 0 waits ----
        srcq[1].push_back({1'b0, 32'hB000_0001});
        srcq[1].push_back({1'b0, 32'hB000_0002});
        srcq[1].push_back({1'b1, 32'hB000_0003});
        srcq[0].push_back({1'b1, 32'hC000_0000});
        otx.delete(); c0 = hist.size();
        for (int i = 0; i < 14; i++) begin
            if (i < 2) en_mask = 4'b0010;
            else if (i < 5) en_mask = 4'b0001;
            else en_mask = 4'b0011;
            cycle();
        end
        en_mask = '1;
        for (int i = 2; i < 5; i++) chk("lock_rdy_hold", 64'(hist[c0+i].rdy), 64'h2);
        chk("lock_count", 64'(otx.size()), 64'd4);
        for (int k = 0; k < 3; k++) begin
            b = get_otx(k);
            chk("lock_order_data", 64'(b.d), 64'(32'hB000_0001 + 32'(k)));
            chk("lock_order_src", 64'(b.s), 64'd1);
        end
        b = get_otx(3);
        chk("lock_ch0_after", 64'(b.d), 64'hC000_0000);

        // ---- back-pressure: out_ready low for 5 cycles ----
        for (int k = 0; k < 8; k++) srcq[3].push_back({(k == 7), 32'hD000_0000 + 32'(k)});
        otx.delete(); c0 = hist.size();
        for (int i = 0; i < 20; i++) begin
            out_ready = !(i >= 3 && i < 8);
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 3; i < 8; i++) begin
            chk("bp_hold_data", 64'(hist[c0+i].d), 64'hD000_0001);
            chk("bp_hold_valid", 64'(hist[c0+i].ov), 64'd1);
            chk("bp_rdy_low", 64'(hist[c0+i].rdy), 64'h0);
        end
        chk("bp_count", 64'(otx.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            b = get_otx(k);
            chk("bp_seq", 64'(b.d), 64'(32'hD000_0000 + 32'(k)));
        end

        // ---- arbitration: all channels with single-beat packets ----
        for (int p = 0; p < 5; p++)
            for (int c = 0; c < N; c++) srcq[c].push_back({1'b1, 32'hE000_0000 + 32'(c*256 + p)});
        otx.delete();
        run(50);
        chk("arb_count", 64'(otx.size()), 64'd20);
        for (int k = 0; k < 5; k++) begin
            b = get_otx(k);
`ifdef STREAM_MUX_RR_EN
            chk("arb_rr_src", 64'(b.s), 64'(k % N));
`else
            chk("arb_fixed_src", 64'(b.s), 64'd0);
`endif
        end

        // ---- reset during beat 2 of a 4-beat packet ----
        for (int k = 0; k < 4; k++) srcq[2].push_back({(k == 3), 32'h6000_0000 + 32'(k)});
        run(2);
        chk("mid_ov_before", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready), 64'h0);
        chk("mid_rst_src", 64'(out_src), 64'd0);
        model_reset();
        for (int c = 0; c < N; c++) srcq[c].delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        srcq[1].push_back({1'b1, 32'h7777_0001});
        otx.delete(); c0 = hist.size();
        run(6);
        chk("post_idle_rdy", 64'(hist[c0].rdy), 64'h0);
        chk("post_grant_rdy", 64'(hist[c0+1].rdy), 64'h2);
        chk("post_data", 64'(hist[c0+2].d), 64'h7777_0001);
        chk("post_src", 64'(hist[c0+2].s), 64'd1);
        chk("post_count", 64'(otx.size()), 64'd1);

        // ---- random traffic against the model ----
        otx.delete(); pushed = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                if (srcq[c].size() < 4 && $urandom_range(0, 7) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) srcq[c].push_back({(k == len - 1), 32'($urandom)});
                    pushed += len;
                end
                en_mask[c] = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        en_mask = '1; out_ready = 1'b1; guard = 0;
        while (busy() && guard < 400) begin
            cycle();
            guard++;
        end
        chk("rand_drained", 64'(busy()), 64'd0);
        chk("rand_count", 64'(otx.size()), 64'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
